// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared types for the DMA write command path
package dmac_pkg;

  localparam int DMAC_ADDR_WD       = 32;
  localparam int DMAC_CHANNEL_COUNT = 8;
  localparam int DMAC_OFFSET_WD     = $clog2(DMAC_ADDR_WD / 8);
  localparam int CH_ID_WD           = $clog2(DMAC_CHANNEL_COUNT);

  typedef logic [CH_ID_WD-1:0] ch_id_t;

  typedef struct packed {
    logic [DMAC_OFFSET_WD-1:0] src_offset;
    logic [DMAC_ADDR_WD-1:0]   dst_addr;
    logic [1:0]                burst;
    logic [DMAC_ADDR_WD-1:0]   len;
    logic [2:0]                size;
  } dmac_wr_cmd_t;

endpackage

// File: rtl/dmac_rr_arbiter.sv
// rtl/dmac_rr_arbiter.sv - round-robin grant over a request vector
// Grant is combinational from req and rr_ptr; rr_ptr moves past the winner on every grant.
module dmac_rr_arbiter #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int IDX_WD = $clog2(N);

  logic [IDX_WD-1:0] rr_ptr;
  logic [IDX_WD-1:0] sel;
  int                idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = IDX_WD'(idx);
      if (!grant_valid && req[sel]) begin
        grant_valid = 1'b1;
        grant[sel]  = 1'b1;
        grant_idx   = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == IDX_WD'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dmac_write_cmd_sched.sv
// rtl/dmac_write_cmd_sched.sv - per-channel write command scheduler
// Arbitrates channel commands onto one registered output with per-channel credit limits.
module dmac_write_cmd_sched
  import dmac_pkg::*;
#(
  parameter int ADDR_WD         = DMAC_ADDR_WD,
  parameter int CHANNEL_COUNT   = DMAC_CHANNEL_COUNT,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [CHANNEL_COUNT-1:0]                        ch_enable,
  input  logic [CHANNEL_COUNT-1:0]                        ch_cmd_valid,
  output logic [CHANNEL_COUNT-1:0]                        ch_cmd_ready,
  input  logic [CHANNEL_COUNT-1:0][$clog2(ADDR_WD/8)-1:0] ch_cmd_src_offset,
  input  logic [CHANNEL_COUNT-1:0][ADDR_WD-1:0]           ch_cmd_dst_addr,
  input  logic [CHANNEL_COUNT-1:0][1:0]                   ch_cmd_burst,
  input  logic [CHANNEL_COUNT-1:0][ADDR_WD-1:0]           ch_cmd_len,
  input  logic [CHANNEL_COUNT-1:0][2:0]                   ch_cmd_size,
  output logic                                            cmd_out_valid,
  input  logic                                            cmd_out_ready,
  output logic [$clog2(ADDR_WD/8)-1:0]                    cmd_out_src_offset,
  output logic [ADDR_WD-1:0]                              cmd_out_dst_addr,
  output logic [1:0]                                      cmd_out_burst,
  output logic [ADDR_WD-1:0]                              cmd_out_len,
  output logic [2:0]                                      cmd_out_size,
  output logic [$clog2(CHANNEL_COUNT)-1:0]                cmd_out_ch_id,
  input  logic                                            done_valid,
  input  logic [$clog2(CHANNEL_COUNT)-1:0]                done_ch_id,
  output logic [CHANNEL_COUNT-1:0]                        ch_busy,
  output logic                                            err_underflow
);

  localparam int ID_WD   = $clog2(CHANNEL_COUNT);
  localparam int CRED_WD = $clog2(MAX_OUTSTANDING + 1);

  logic [CRED_WD-1:0]       credit     [CHANNEL_COUNT];
  logic [CRED_WD-1:0]       credit_nxt [CHANNEL_COUNT];
  logic [CHANNEL_COUNT-1:0] eligible;
  logic [CHANNEL_COUNT-1:0] req;
  logic [CHANNEL_COUNT-1:0] has_credit;
  logic [CHANNEL_COUNT-1:0] done_hit;
  logic [CHANNEL_COUNT-1:0] busy_nxt;
  logic [ID_WD-1:0]         grant_idx;
  logic                     grant_valid;
  logic                     slot_free;
  logic                     load_cmd;
  dmac_wr_cmd_t             cmd_q;
  dmac_wr_cmd_t             cmd_sel;
  ch_id_t                   ch_id_q;

  assign slot_free = !cmd_out_valid || cmd_out_ready;
  assign req       = (slot_free && !rst) ? eligible : '0;

  dmac_rr_arbiter #(
    .N (CHANNEL_COUNT)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (ch_cmd_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Zero-length commands are accepted to unblock the source but never issued or credited.
  assign load_cmd = grant_valid && (ch_cmd_len[grant_idx] != '0);

  always_comb begin
    cmd_sel            = '0;
    cmd_sel.src_offset = ch_cmd_src_offset[grant_idx];
    cmd_sel.dst_addr   = ch_cmd_dst_addr[grant_idx];
    cmd_sel.burst      = ch_cmd_burst[grant_idx];
    cmd_sel.len        = ch_cmd_len[grant_idx];
    cmd_sel.size       = ch_cmd_size[grant_idx];
  end

  for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_ch
    logic inc;
    logic dec;

    assign has_credit[i] = (credit[i] != '0);
    assign done_hit[i]   = done_valid && (done_ch_id == ID_WD'(i));
    assign eligible[i]   = ch_enable[i] && ch_cmd_valid[i] &&
                           (credit[i] < CRED_WD'(MAX_OUTSTANDING));
    assign inc           = load_cmd && (grant_idx == ID_WD'(i));
    assign dec           = done_hit[i] && has_credit[i];
    assign credit_nxt[i] = (inc && !dec) ? credit[i] + 1'b1 :
                           (dec && !inc) ? credit[i] - 1'b1 : credit[i];
    assign busy_nxt[i]   = (credit_nxt[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) credit[i] <= '0;
      ch_busy       <= '0;
      err_underflow <= 1'b0;
    end else begin
      credit        <= credit_nxt;
      ch_busy       <= busy_nxt;
      err_underflow <= done_valid && !(|(done_hit & has_credit));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q         <= '0;
      ch_id_q       <= '0;
      cmd_out_valid <= 1'b0;
    end else if (load_cmd) begin
      cmd_q         <= cmd_sel;
      ch_id_q       <= grant_idx;
      cmd_out_valid <= 1'b1;
    end else if (cmd_out_ready) begin
      cmd_out_valid <= 1'b0;
    end
  end

  assign cmd_out_src_offset = cmd_q.src_offset;
  assign cmd_out_dst_addr   = cmd_q.dst_addr;
  assign cmd_out_burst      = cmd_q.burst;
  assign cmd_out_len        = cmd_q.len;
  assign cmd_out_size       = cmd_q.size;
  assign cmd_out_ch_id      = ch_id_q;

endmodule

// File: tb/tb_dmac_write_cmd_sched.sv
// tb/tb_dmac_write_cmd_sched.sv - scoreboard bench for dmac_write_cmd_sched
module tb_dmac_write_cmd_sched;

  localparam int AW   = 32;
  localparam int CH   = 8;
  localparam int MAXO = 4;

  typedef struct {
    int         ch;
    logic [1:0] off;
    logic [31:0] dst;
    logic [1:0] burst;
    logic [31:0] len;
    logic [2:0] size;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [CH-1:0]         ch_enable;
  logic [CH-1:0]         ch_cmd_valid;
  logic [CH-1:0]         ch_cmd_ready;
  logic [CH-1:0][1:0]    ch_cmd_src_offset;
  logic [CH-1:0][AW-1:0] ch_cmd_dst_addr;
  logic [CH-1:0][1:0]    ch_cmd_burst;
  logic [CH-1:0][AW-1:0] ch_cmd_len;
  logic [CH-1:0][2:0]    ch_cmd_size;
  logic                  cmd_out_valid;
  logic                  cmd_out_ready;
  logic [1:0]            cmd_out_src_offset;
  logic [AW-1:0]         cmd_out_dst_addr;
  logic [1:0]            cmd_out_burst;
  logic [AW-1:0]         cmd_out_len;
  logic [2:0]            cmd_out_size;
  logic [2:0]            cmd_out_ch_id;
  logic                  done_valid;
  logic [2:0]            done_ch_id;
  logic [CH-1:0]         ch_busy;
  logic                  err_underflow;

  dmac_write_cmd_sched #(
    .ADDR_WD         (AW),
    .CHANNEL_COUNT   (CH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ch_enable          (ch_enable),
    .ch_cmd_valid       (ch_cmd_valid),
    .ch_cmd_ready       (ch_cmd_ready),
    .ch_cmd_src_offset  (ch_cmd_src_offset),
    .ch_cmd_dst_addr    (ch_cmd_dst_addr),
    .ch_cmd_burst       (ch_cmd_burst),
    .ch_cmd_len         (ch_cmd_len),
    .ch_cmd_size        (ch_cmd_size),
    .cmd_out_valid      (cmd_out_valid),
    .cmd_out_ready      (cmd_out_ready),
    .cmd_out_src_offset (cmd_out_src_offset),
    .cmd_out_dst_addr   (cmd_out_dst_addr),
    .cmd_out_burst      (cmd_out_burst),
    .cmd_out_len        (cmd_out_len),
    .cmd_out_size       (cmd_out_size),
    .cmd_out_ch_id      (cmd_out_ch_id),
    .done_valid         (done_valid),
    .done_ch_id         (done_ch_id),
    .ch_busy            (ch_busy),
    .err_underflow      (err_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t sb[$];
  int   grant_log[$];
  int   grant_cnt[CH];

  int         m_rr;
  int         m_cred[CH];
  bit         m_out_valid;
  logic [CH-1:0] m_busy;
  bit         m_err;

  logic [CH-1:0] obs_ready;
  logic [CH-1:0] obs_busy;
  logic          obs_out_valid;
  logic          obs_err;
  logic [2:0]    obs_ch_id;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_counts();
    grant_log.delete();
    for (int i = 0; i < CH; i++) grant_cnt[i] = 0;
  endtask

  task automatic run_cycle();
    int            g;
    int            idx;
    bit            slot_free;
    logic [CH-1:0] exp_ready;
    exp_t          e;
    int            nc;
    @(negedge clk);
    slot_free = !m_out_valid || cmd_out_ready;
    g = -1;
    if (!rst && slot_free) begin
      for (int k = 0; k < CH; k++) begin
        idx = (m_rr + k) % CH;
        if (g < 0 && ch_enable[idx] && ch_cmd_valid[idx] && m_cred[idx] < MAXO) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;

    obs_ready     = ch_cmd_ready;
    obs_busy      = ch_busy;
    obs_out_valid = cmd_out_valid;
    obs_err       = err_underflow;
    obs_ch_id     = cmd_out_ch_id;
    for (int k = 0; k < CH; k++) begin
      if (ch_cmd_ready[k]) begin
        grant_cnt[k]++;
        grant_log.push_back(k);
      end
    end

    check_val("ch_cmd_ready", 64'(ch_cmd_ready), 64'(exp_ready));
    check_val("cmd_out_valid", 64'(cmd_out_valid), 64'(m_out_valid));
    check_val("ch_busy", 64'(ch_busy), 64'(m_busy));
    check_val("err_underflow", 64'(err_underflow), 64'(m_err));

    if (cmd_out_valid) begin
      if (sb.size() == 0) begin
        check_val("sb_empty", 64'(1), 64'(0));
      end else begin
        e = sb[0];
        check_val("out_ch_id", 64'(cmd_out_ch_id), 64'(e.ch));
        check_val("out_dst_addr", 64'(cmd_out_dst_addr), 64'(e.dst));
        check_val("out_len", 64'(cmd_out_len), 64'(e.len));
        check_val("out_misc", 64'({cmd_out_src_offset, cmd_out_burst, cmd_out_size}),
                  64'({e.off, e.burst, e.size}));
        if (cmd_out_ready) void'(sb.pop_front());
      end
    end

    if (rst) begin
      m_rr = 0;
      m_out_valid = 1'b0;
      m_busy = '0;
      m_err = 1'b0;
      for (int i = 0; i < CH; i++) m_cred[i] = 0;
      sb.delete();
    end else begin
      m_err = done_valid && (m_cred[done_ch_id] == 0);
      if (g >= 0) begin
        m_rr = (g + 1) % CH;
        if (ch_cmd_len[g] != 0) begin
          e.ch = g; e.off = ch_cmd_src_offset[g]; e.dst = ch_cmd_dst_addr[g];
          e.burst = ch_cmd_burst[g]; e.len = ch_cmd_len[g]; e.size = ch_cmd_size[g];
          sb.push_back(e);
          m_out_valid = 1'b1;
        end else if (cmd_out_ready) begin
          m_out_valid = 1'b0;
        end
      end else if (cmd_out_ready) begin
        m_out_valid = 1'b0;
      end
      for (int i = 0; i < CH; i++) begin
        nc = m_cred[i];
        if (g == i && ch_cmd_len[i] != 0) nc++;
        if (done_valid && done_ch_id == 3'(i) && m_cred[i] != 0) nc--;
        m_cred[i] = nc;
        m_busy[i] = (nc != 0);
      end
    end

    @(posedge clk);
    #1;
    if (g >= 0 && !rst) begin
      ch_cmd_dst_addr[g] = ch_cmd_dst_addr[g] + 32'h40;
      if (ch_cmd_len[g] != 0) ch_cmd_len[g] = ch_cmd_len[g] + 32'h8;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    run_cycles(2);
    rst = 1'b0;
    clear_counts();
  endtask

  initial begin
    rst = 1'b1;
    ch_enable = '1;
    ch_cmd_valid = '0;
    cmd_out_ready = 1'b1;
    done_valid = 1'b0;
    done_ch_id = '0;
    for (int i = 0; i < CH; i++) begin
      ch_cmd_src_offset[i] = 2'(i);
      ch_cmd_dst_addr[i]   = 32'h1000_0000 + (i << 16);
      ch_cmd_burst[i]      = 2'b01;
      ch_cmd_len[i]        = 32'(64 + 16 * i);
      ch_cmd_size[i]       = 3'(i);
    end
    m_rr = 0; m_out_valid = 1'b0; m_busy = '0; m_err = 1'b0;
    for (int i = 0; i < CH; i++) m_cred[i] = 0;
    clear_counts();
    #1;

    apply_reset();
    check_val("rst_out_valid", 64'(obs_out_valid), 64'(0));
    check_val("rst_busy", 64'(obs_busy), 64'(0));

    ch_cmd_len[2] = 32'd64;
    ch_cmd_valid = 8'h04;
    run_cycle();
    check_val("single_ready", 64'(obs_ready), 64'(8'h04));
    ch_cmd_valid = '0;
    run_cycle();
    check_val("single_out_valid", 64'(obs_out_valid), 64'(1));
    check_val("single_ch_id", 64'(obs_ch_id), 64'(2));
    check_val("single_busy2", 64'(obs_busy[2]), 64'(1));
    done_valid = 1'b1; done_ch_id = 3'd2;
    run_cycle();
    done_valid = 1'b0;
    run_cycle();
    check_val("single_busy_clear", 64'(obs_busy), 64'(0));

    apply_reset();
    ch_cmd_valid = '1;
    run_cycles(9);
    check_val("rr_grants", 64'(grant_log.size()), 64'(9));
    for (int k = 0; k < 9 && k < grant_log.size(); k++)
      check_val($sformatf("rr_order%0d", k), 64'(grant_log[k]), 64'(k % CH));
    ch_cmd_valid = '0;

    apply_reset();
    ch_cmd_valid = 8'h01;
    run_cycles(8);
    check_val("credit_limit", 64'(grant_cnt[0]), 64'(MAXO));
    done_valid = 1'b1; done_ch_id = 3'd0;
    run_cycle();
    done_valid = 1'b0;
    run_cycles(5);
    check_val("credit_one_more", 64'(grant_cnt[0]), 64'(MAXO + 1));
    check_val("credit_stalled", 64'(obs_ready), 64'(0));
    ch_cmd_valid = '0;

    apply_reset();
    ch_cmd_valid = 8'h12;
    cmd_out_ready = 1'b0;
    run_cycle();
    check_val("stall_first", 64'(obs_ready), 64'(8'h02));
    run_cycles(5);
    check_val("stall_no_grant", 64'(grant_cnt[1] + grant_cnt[4]), 64'(1));
    check_val("stall_ch_id", 64'(obs_ch_id), 64'(1));
    cmd_out_ready = 1'b1;
    run_cycle();
    check_val("stall_release", 64'(obs_ready), 64'(8'h10));
    ch_cmd_valid = '0;
    run_cycles(2);

    apply_reset();
    ch_cmd_valid = 8'h08;
    run_cycles(2);
    done_valid = 1'b1; done_ch_id = 3'd3;
    run_cycle();
    done_valid = 1'b0;
    run_cycles(4);
    check_val("grant_done_same", 64'(grant_cnt[3]), 64'(5));
    ch_cmd_valid = '0;
    done_valid = 1'b1; done_ch_id = 3'd5;
    run_cycle();
    done_valid = 1'b0;
    run_cycle();
    check_val("underflow_pulse", 64'(obs_err), 64'(1));
    run_cycle();
    check_val("underflow_clear", 64'(obs_err), 64'(0));

    apply_reset();
    ch_cmd_len[1] = '0;
    ch_cmd_valid = 8'h02;
    run_cycle();
    check_val("len0_ready", 64'(obs_ready), 64'(8'h02));
    ch_cmd_valid = '0;
    run_cycle();
    check_val("len0_no_out", 64'(obs_out_valid), 64'(0));
    check_val("len0_busy1", 64'(obs_busy[1]), 64'(0));
    ch_cmd_len[1] = 32'd128;

    ch_cmd_valid = '1;
    run_cycles(3);
    rst = 1'b1;
    run_cycles(2);
    check_val("midrst_ready", 64'(obs_ready), 64'(0));
    check_val("midrst_out_valid", 64'(obs_out_valid), 64'(0));
    check_val("midrst_busy", 64'(obs_busy), 64'(0));
    check_val("midrst_dst", 64'(cmd_out_dst_addr), 64'(0));
    rst = 1'b0;
    ch_cmd_valid = '0;
    run_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
